// File: rtl/taillight_pkg.sv
// Shared definitions for the taillight sweep logic.
// Holds the sweep state encoding and the sequence-length derivation so the
// arbiter and taillight_controller always agree on how long one sweep lasts.
package taillight_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam int STEP_CYCLES_DEF = 5;

  // One full sweep is four lamp steps.
  function automatic int seq_len(input int step_cycles);
    return 4 * step_cycles;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Purpose: 2-flop synchroniser plus debounce filter for one raw switch input.
// Latency: raw edge sampled at edge 1 shows on filtered at edge DEBOUNCE_CYCLES+2.
// Backpressure: none, level signal in and out.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   raw         asynchronous, possibly bouncing switch level
//   filtered    debounced level, changes only after DEBOUNCE_CYCLES stable cycles
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      filtered <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Count consecutive cycles where the synchronised value disagrees with
      // the filtered level; a single agreeing cycle restarts the count.
      if (sync2 == filtered) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filtered <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/taillight_request_arbiter.sv
// Purpose: condition driver stalk/brake inputs and sequence whole turn sweeps for taillight_controller.
// Latency: raw edge sampled at edge 1 reaches the registered outputs at edge DEBOUNCE_CYCLES+3.
// Backpressure: none; level inputs, turn changes deferred to sweep boundaries.
// Ports:
//   clk, rst_n                                   clock and asynchronous active-low reset
//   stalk_left_raw, stalk_right_raw, brake_raw   raw asynchronous switch levels
//   turn_left, turn_right, brake                 registered controls to taillight_controller
//   busy                                         high while a turn sweep is running
module taillight_request_arbiter
  import taillight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int STEP_CYCLES        = STEP_CYCLES_DEF,
  parameter int LANE_CHANGE_PASSES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stalk_left_raw,
  input  logic stalk_right_raw,
  input  logic brake_raw,
  output logic turn_left,
  output logic turn_right,
  output logic brake,
  output logic busy
);

  localparam int SEQ_LEN = seq_len(STEP_CYCLES);
  localparam int SEQ_W   = $clog2(SEQ_LEN);
  localparam int PASS_W  = $clog2(LANE_CHANGE_PASSES + 1);

  localparam logic [SEQ_W-1:0]  SEQ_LAST = SEQ_W'(SEQ_LEN - 1);
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(LANE_CHANGE_PASSES);

  logic filt_l;
  logic filt_r;
  logic filt_b;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (stalk_left_raw),
    .filtered (filt_l)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (stalk_right_raw),
    .filtered (filt_r)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_brake (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (brake_raw),
    .filtered (filt_b)
  );

  // Both stalks at once is ambiguous, so it counts as no request at all.
  logic req_l;
  logic req_r;
  assign req_l = filt_l & ~filt_r;
  assign req_r = filt_r & ~filt_l;

  state_t              state_q;
  state_t              state_d;
  logic [SEQ_W-1:0]    seq_q;
  logic [SEQ_W-1:0]    seq_d;
  logic [PASS_W-1:0]   passes_q;
  logic [PASS_W-1:0]   passes_d;

  // Requests seen from the point of view of the current sweep direction.
  logic req_same;
  logic req_opp;
  assign req_same = (state_q == LEFT) ? req_l : req_r;
  assign req_opp  = (state_q == LEFT) ? req_r : req_l;

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    passes_d = passes_q;
    case (state_q)
      IDLE: begin
        if (req_l) begin
          state_d  = LEFT;
          seq_d    = '0;
          passes_d = '0;
        end else if (req_r) begin
          state_d  = RIGHT;
          seq_d    = '0;
          passes_d = '0;
        end
      end
      LEFT, RIGHT: begin
        if (seq_q == SEQ_LAST) begin
          // Only the last cycle of a sweep may change direction or stop.
          seq_d = '0;
          if (req_opp) begin
            state_d  = (state_q == LEFT) ? RIGHT : LEFT;
            passes_d = '0;
          end else if (req_same) begin
            passes_d = (passes_q == PASS_MAX) ? passes_q : passes_q + PASS_W'(1);
          end else if (int'(passes_q) + 1 < LANE_CHANGE_PASSES) begin
            passes_d = passes_q + PASS_W'(1);
          end else begin
            state_d  = IDLE;
            passes_d = '0;
          end
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        seq_d    = '0;
        passes_d = '0;
      end
    endcase
  end

  // Turn outputs are loaded from the next state on the same edge as the
  // state register, so a direction switch swaps them without overlap or gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      passes_q   <= '0;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      brake      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      passes_q   <= passes_d;
      turn_left  <= (state_d == LEFT);
      turn_right <= (state_d == RIGHT);
      brake      <= filt_b;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_taillight_request_arbiter.sv
module tb_taillight_request_arbiter;

  localparam int D    = 4;
  localparam int STEP = 5;
  localparam int LCP  = 3;
  localparam int SEQ  = 4 * STEP;
  localparam int HMAX = 4096;

  logic clk;
  logic rst_n;
  logic stalk_left_raw;
  logic stalk_right_raw;
  logic brake_raw;
  logic turn_left;
  logic turn_right;
  logic brake;
  logic busy;

  taillight_request_arbiter #(
    .DEBOUNCE_CYCLES    (D),
    .STEP_CYCLES        (STEP),
    .LANE_CHANGE_PASSES (LCP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stalk_left_raw  (stalk_left_raw),
    .stalk_right_raw (stalk_right_raw),
    .brake_raw       (brake_raw),
    .turn_left       (turn_left),
    .turn_right      (turn_right),
    .brake           (brake),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Raw samples taken at each edge since reset; the filter rule is stated
  // directly: a filtered level flips once the last D synchronised samples
  // (two edges old) all disagree with it.
  bit hist [3][HMAX];
  int nedge;
  bit filt [3];
  int dir;      // 0 none, 1 left, 2 right
  int pos;      // cycle within the current sweep
  int passes;   // completed sweeps counted toward the minimum
  bit e_tl, e_tr, e_br;

  function automatic bit raw_at(input int i, input int k);
    if (k < 0 || k >= HMAX) return 1'b0;
    return hist[i][k];
  endfunction

  function automatic void model_reset();
    nedge = 0;
    for (int i = 0; i < 3; i++) filt[i] = 1'b0;
    dir = 0; pos = 0; passes = 0;
    e_tl = 1'b0; e_tr = 1'b0; e_br = 1'b0;
  endfunction

  function automatic void model_step();
    bit raw [3];
    bit of [3];
    bit rl, rr, same, opp, all_diff;
    raw[0] = stalk_left_raw; raw[1] = stalk_right_raw; raw[2] = brake_raw;
    for (int i = 0; i < 3; i++) begin
      if (nedge < HMAX) hist[i][nedge] = raw[i];
      of[i] = filt[i];
    end
    rl = of[0] & ~of[1];
    rr = of[1] & ~of[0];
    if (dir == 0) begin
      if (rl) begin dir = 1; pos = 0; passes = 0; end
      else if (rr) begin dir = 2; pos = 0; passes = 0; end
    end else if (pos == SEQ - 1) begin
      same = (dir == 1) ? rl : rr;
      opp  = (dir == 1) ? rr : rl;
      pos = 0;
      if (opp) begin dir = 3 - dir; passes = 0; end
      else if (same) passes = (passes + 1 > LCP) ? LCP : passes + 1;
      else if (passes + 1 < LCP) passes = passes + 1;
      else begin dir = 0; passes = 0; end
    end else begin
      pos = pos + 1;
    end
    e_tl = (dir == 1);
    e_tr = (dir == 2);
    e_br = of[2];
    for (int i = 0; i < 3; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (raw_at(i, nedge - 2 - j) == filt[i]) all_diff = 1'b0;
      if (all_diff) filt[i] = ~filt[i];
    end
    nedge++;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Per-scenario statistics
  int cyc, tl_cnt, tr_cnt, busy_cnt, br_cnt, tl_rise, both_cnt, sw_cnt;
  int tl_first, br_first, br_mark;
  bit prev_tl, prev_tr, prev_br;

  task automatic clr_stats();
    cyc = 0; tl_cnt = 0; tr_cnt = 0; busy_cnt = 0; br_cnt = 0;
    tl_rise = 0; both_cnt = 0; sw_cnt = 0;
    tl_first = -1; br_first = -1; br_mark = 0;
    prev_tl = turn_left; prev_tr = turn_right; prev_br = brake;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      @(negedge clk);
      chk("turn_left",  turn_left,  e_tl);
      chk("turn_right", turn_right, e_tr);
      chk("brake",      brake,      e_br);
      chk("busy",       busy,       e_tl | e_tr);
      cyc++;
      if (turn_left)  tl_cnt++;
      if (turn_right) tr_cnt++;
      if (busy)       busy_cnt++;
      if (brake)      br_cnt++;
      if (turn_left && turn_right) both_cnt++;
      if (turn_left && !prev_tl) tl_rise++;
      if (turn_left && tl_first < 0) tl_first = cyc;
      if (brake && !prev_br && br_first < 0) br_first = cyc - br_mark;
      if (prev_tl && !turn_left && turn_right && !prev_tr) sw_cnt++;
      prev_tl = turn_left; prev_tr = turn_right; prev_br = brake;
    end
  endtask

  task automatic wait_tl(input int lim, input string tag);
    int k;
    k = 0;
    while (!turn_left && k < lim) begin
      run(1);
      k++;
    end
    chk_int(tag, int'(turn_left), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    stalk_left_raw = 1'b0; stalk_right_raw = 1'b0; brake_raw = 1'b0;
    model_reset();
    run(3);
    chk("reset_tl", turn_left, 1'b0);
    chk("reset_tr", turn_right, 1'b0);
    chk("reset_br", brake, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    run(5);

    // Lane-change tap: three whole sweeps.
    clr_stats();
    stalk_left_raw = 1'b1; run(10);
    stalk_left_raw = 1'b0; run(80);
    chk_int("tap_rise_edge", tl_first, 7);
    chk_int("tap_tl_len", tl_cnt, 3 * SEQ);
    chk_int("tap_busy_len", busy_cnt, 3 * SEQ);
    chk_int("tap_tr_len", tr_cnt, 0);

    // Hold extension: five whole sweeps.
    clr_stats();
    stalk_right_raw = 1'b1; run(90);
    stalk_right_raw = 1'b0; run(60);
    chk_int("hold_tr_len", tr_cnt, 5 * SEQ);
    chk_int("hold_tl_len", tl_cnt, 0);

    // Bounce: toggling every 2 cycles never passes the filter.
    clr_stats();
    for (int i = 0; i < 10; i++) begin
      stalk_left_raw = ~stalk_left_raw;
      run(2);
    end
    stalk_left_raw = 1'b0; run(20);
    chk_int("bounce_tl_len", tl_cnt, 0);

    // Conflict: both stalks together is no request.
    clr_stats();
    stalk_left_raw = 1'b1; stalk_right_raw = 1'b1; run(40);
    stalk_left_raw = 1'b0; stalk_right_raw = 1'b0; run(20);
    chk_int("both_tl_len", tl_cnt, 0);
    chk_int("both_tr_len", tr_cnt, 0);
    chk_int("both_busy_len", busy_cnt, 0);

    // Direction change at sweep cycle 8.
    clr_stats();
    stalk_left_raw = 1'b1;
    wait_tl(20, "dir_tl_start");
    run(8);
    stalk_left_raw = 1'b0; stalk_right_raw = 1'b1; run(30);
    stalk_right_raw = 1'b0; run(120);
    chk_int("dir_tl_len", tl_cnt, SEQ);
    chk_int("dir_switch", sw_cnt, 1);
    chk_int("dir_tr_len", tr_cnt, 3 * SEQ);
    chk_int("dir_overlap", both_cnt, 0);

    // Brake pulse during a left sweep.
    clr_stats();
    stalk_left_raw = 1'b1; run(15);
    brake_raw = 1'b1; br_mark = cyc; run(12);
    brake_raw = 1'b0; run(35);
    stalk_left_raw = 1'b0; run(60);
    chk_int("brake_len", br_cnt, 12);
    chk_int("brake_delay", br_first, 7);
    chk_int("brake_tl_len", tl_cnt, 4 * SEQ);
    chk_int("brake_tl_rises", tl_rise, 1);

    // Randomised holds and glitches against the model.
    clr_stats();
    for (int k = 0; k < 40; k++) begin
      stalk_left_raw  = 1'($urandom_range(0, 1));
      stalk_right_raw = 1'($urandom_range(0, 1));
      brake_raw       = 1'($urandom_range(0, 1));
      run($urandom_range(1, 40));
    end
    stalk_left_raw = 1'b0; stalk_right_raw = 1'b0; brake_raw = 1'b0;
    run(120);
    chk_int("rand_overlap", both_cnt, 0);

    // Reset in the middle of a sweep.
    clr_stats();
    stalk_left_raw = 1'b1;
    wait_tl(20, "rst_tl_start");
    run(29);
    chk("rst_pre_tl", turn_left, 1'b1);
    #2 rst_n = 1'b0;
    stalk_left_raw = 1'b0;
    #1;
    chk("rst_async_tl", turn_left, 1'b0);
    chk("rst_async_tr", turn_right, 1'b0);
    chk("rst_async_br", brake, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    clr_stats();
    run(60);
    chk_int("post_rst_tl_len", tl_cnt, 0);
    chk_int("post_rst_busy_len", busy_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
